// File: rtl/s27_bist_pkg.sv
// s27_bist_pkg: shared types and helpers for the s27 BIST controller.
package s27_bist_pkg;

    localparam int unsigned PAT_W       = 4;
    localparam int unsigned LFSR_TAP_HI = 3;
    localparam int unsigned LFSR_TAP_LO = 2;
    localparam logic [15:0] MISR_POLY   = 16'h1021;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_RUN   = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // All-zero is the LFSR lock-up state, so it is replaced by 1.
    function automatic logic [PAT_W-1:0] seed_fix(input logic [PAT_W-1:0] s);
        return (s == '0) ? PAT_W'(1) : s;
    endfunction

    // One step of x^4+x^3+1, period 15.
    function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] v);
        return {v[PAT_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/s27_bist_misr.sv
// s27_bist_misr: single-input signature register compacting the s27 G17 stream.
module s27_bist_misr
    import s27_bist_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY)
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    // Shift with polynomial feedback, folding the observed bit into the LSB.
    always_ff @(posedge CK) begin
        if (!RST_N) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(din);
        end
    end

endmodule

// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl: LFSR-driven BIST for the s27 core with MISR compaction of G17
// and a golden-signature compare.
// Optional macro S27_BIST_SEED_LOAD_EN adds SEED_IN, captured as LFSR seed on START.
module s27_bist_ctrl
    import s27_bist_pkg::*;
#(
    parameter logic [PAT_W-1:0] LFSR_SEED = 4'b1001,
    parameter logic [PAT_W-1:0] FLUSH_PAT = 4'b0011,
    parameter int unsigned      FLUSH_CYC = 2,
    parameter int unsigned      N_PAT     = 15,
    parameter int unsigned      SIG_W     = 16,
    parameter logic [SIG_W-1:0] POLY      = SIG_W'(MISR_POLY)
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [SIG_W-1:0] GOLDEN,
    input  logic             PO_G17,
`ifdef S27_BIST_SEED_LOAD_EN
    input  logic [PAT_W-1:0] SEED_IN,
`endif
    output logic [PAT_W-1:0] PI_G,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIG_W-1:0] SIG
);

    localparam int unsigned      CNT_W      = 16;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PAT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [PAT_W-1:0]   lfsr;
    logic [PAT_W-1:0]   lfsr_nxt;
    logic [PAT_W-1:0]   pi_nxt;
    logic [PAT_W-1:0]   start_seed;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               pass_nxt;
    logic               start_acc_c;
    logic               misr_en_c;

`ifdef S27_BIST_SEED_LOAD_EN
    assign start_seed = seed_fix(SEED_IN);
`else
    assign start_seed = seed_fix(LFSR_SEED);
`endif

    // State register.
    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counters, LFSR and next output values.
    always_comb begin
        state_nxt   = state;
        lfsr_nxt    = lfsr;
        cnt_nxt     = cnt;
        pass_nxt    = PASS;
        start_acc_c = 1'b0;
        misr_en_c   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_nxt   = S_FLUSH;
                    lfsr_nxt    = start_seed;
                    cnt_nxt     = '0;
                    pass_nxt    = 1'b0;
                    start_acc_c = 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                misr_en_c = 1'b1;
                lfsr_nxt  = lfsr_step(lfsr);
                if (cnt == RUN_LAST) begin
                    state_nxt = S_CMP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_CMP: begin
                state_nxt = S_DONE;
                pass_nxt  = (SIG == GOLDEN);
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == S_FLUSH) || (state_nxt == S_RUN) || (state_nxt == S_CMP);
        done_nxt = (state_nxt == S_DONE);
        pi_nxt   = (state_nxt == S_RUN) ? lfsr_nxt : FLUSH_PAT;
    end

    // Datapath and registered outputs; PI_G shows the pattern for the whole RUN cycle.
    always_ff @(posedge CK) begin
        if (!RST_N) begin
            lfsr <= seed_fix(LFSR_SEED);
            cnt  <= '0;
            PI_G <= FLUSH_PAT;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            PASS <= 1'b0;
        end else begin
            lfsr <= lfsr_nxt;
            cnt  <= cnt_nxt;
            PI_G <= pi_nxt;
            BUSY <= busy_nxt;
            DONE <= done_nxt;
            PASS <= pass_nxt;
        end
    end

    s27_bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .CK    (CK),
        .RST_N (RST_N),
        .clr   (start_acc_c),
        .en    (misr_en_c),
        .din   (PO_G17),
        .sig   (SIG)
    );

endmodule
